sha256_iter_core: RTL and testbench



---
 rtl/sha256_iter_core_if.sv | 23 ++
 rtl/sha256_iter_core.sv | 112 +++++++++++
 tb/tb_sha256_iter_core.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_iter_core_if.sv
// sha256_iter_core_if: job input/output handshake bundle for sha256_iter_core.
interface sha256_iter_core_if #(
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [511:0]     in_w;
  logic [255:0]     in_h;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [255:0]     out_h;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  modport master (
    output in_valid, in_w, in_h, in_tag, out_ready,
    input  in_ready, out_valid, out_h, out_tag, busy
  );
  modport slave (
    input  in_valid, in_w, in_h, in_tag, out_ready,
    output in_ready, out_valid, out_h, out_tag, busy
  );
endinterface

// File: rtl/sha256_iter_core.sv
// sha256_iter_core: iterative SHA-256 compression, ROUNDS_PER_CYCLE rounds per clock,
// with in/out valid-ready handshakes and a pass-through job tag.
module sha256_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int TAG_W = 32
) (
  input logic               clk,
  input logic               reset_n,
  sha256_iter_core_if.slave bus
);
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_r
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  typedef logic [0:7][31:0] hv_t;
  typedef logic [0:15][31:0] wv_t;
  typedef struct packed {
    hv_t v;
    wv_t w;
  } st_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  // Chains the rounds of one clock; the window w[0..15] always holds W[t..t+15].
  function automatic st_t step_f(input st_t s, input logic [5:0] t);
    st_t r;
    logic [31:0] t1, t2, nw;
    r = s;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      t1 = r.v[7] + (rotr(r.v[4], 6) ^ rotr(r.v[4], 11) ^ rotr(r.v[4], 25))
         + ((r.v[4] & r.v[5]) ^ (~r.v[4] & r.v[6])) + K[t + 6'(i)] + r.w[0];
      t2 = (rotr(r.v[0], 2) ^ rotr(r.v[0], 13) ^ rotr(r.v[0], 22))
         + ((r.v[0] & r.v[1]) ^ (r.v[0] & r.v[2]) ^ (r.v[1] & r.v[2]));
      nw = (rotr(r.w[14], 17) ^ rotr(r.w[14], 19) ^ (r.w[14] >> 10)) + r.w[9]
         + (rotr(r.w[1], 7) ^ rotr(r.w[1], 18) ^ (r.w[1] >> 3)) + r.w[0];
      r.v = {t1 + t2, r.v[0:2], r.v[3] + t1, r.v[4:6]};
      r.w = {r.w[1:15], nw};
    end
    return r;
  endfunction
  state_e           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  st_t              cur_q, cur_d, nxt;
  hv_t              hs_q, hs_d, out_h_q, out_h_d;
  logic [TAG_W-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
  logic             ov_q, accept, last;
  assign bus.in_ready  = state_q == IDLE || (state_q == DONE && bus.out_ready);
  assign bus.out_valid = ov_q;
  assign bus.out_h     = out_h_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.busy      = state_q == RUN;
  assign accept        = bus.in_valid && bus.in_ready;
  assign nxt           = step_f(cur_q, cnt_q[5:0]);
  assign last          = cnt_q + 7'(ROUNDS_PER_CYCLE) == 7'd64;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    hs_d      = hs_q;
    tag_d     = tag_q;
    out_h_d   = out_h_q;
    out_tag_d = out_tag_q;
    if (state_q == RUN) begin
      cur_d = nxt;
      cnt_d = cnt_q + 7'(ROUNDS_PER_CYCLE);
      if (last) begin
        for (int i = 0; i < 8; i++) out_h_d[i] = hs_q[i] + nxt.v[i];
        out_tag_d = tag_q;
        state_d   = DONE;
      end
    end else if (accept) begin
      cur_d   = {bus.in_h, bus.in_w};
      hs_d    = bus.in_h;
      tag_d   = bus.in_tag;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_q     <= '0;
      hs_q      <= '0;
      tag_q     <= '0;
      out_h_q   <= '0;
      out_tag_q <= '0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      hs_q      <= hs_d;
      tag_q     <= tag_d;
      out_h_q   <= out_h_d;
      out_tag_q <= out_tag_d;
      ov_q      <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_sha256_iter_core.sv
// tb_sha256_iter_core: known-answer, handshake and randomized checks of sha256_iter_core
// against an array-based SHA-256 compression model.
module tb_sha256_iter_core;
  localparam logic [255:0] H0     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_H  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPT_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] ABC_W  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPT_W = {32'h80000000, 480'h0};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  sha256_iter_core_if #(.TAG_W(32)) bus  ();
  sha256_iter_core_if #(.TAG_W(32)) bus2 ();
  sha256_iter_core_if #(.TAG_W(32)) bus4 ();
  sha256_iter_core_if #(.TAG_W(32)) bus8 ();
  sha256_iter_core #(.ROUNDS_PER_CYCLE(1), .TAG_W(32)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  sha256_iter_core #(.ROUNDS_PER_CYCLE(2), .TAG_W(32)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  sha256_iter_core #(.ROUNDS_PER_CYCLE(4), .TAG_W(32)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
  sha256_iter_core #(.ROUNDS_PER_CYCLE(8), .TAG_W(32)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));
  // The R=2 and R=8 cores mirror the R=4 core's inputs; only their latency/result is checked.
  assign bus2.in_valid  = bus4.in_valid;
  assign bus2.in_w      = bus4.in_w;
  assign bus2.in_h      = bus4.in_h;
  assign bus2.in_tag    = bus4.in_tag;
  assign bus2.out_ready = bus4.out_ready;
  assign bus8.in_valid  = bus4.in_valid;
  assign bus8.in_w      = bus4.in_w;
  assign bus8.in_h      = bus4.in_h;
  assign bus8.in_tag    = bus4.in_tag;
  assign bus8.out_ready = bus4.out_ready;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic acc, xfer, acc4, xfer4;
  logic [255:0] oh_s, oh4_s;
  logic [31:0] ot_s, ot4_s;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction
  function automatic logic [255:0] ref_hash(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = v[i] + hin[255-32*i -: 32];
    return res;
  endfunction
  task automatic tick();
    @(negedge clk);
    acc   = bus.in_valid && bus.in_ready;
    xfer  = bus.out_valid && bus.out_ready;
    oh_s  = bus.out_h;
    ot_s  = bus.out_tag;
    acc4  = bus4.in_valid && bus4.in_ready;
    xfer4 = bus4.out_valid && bus4.out_ready;
    oh4_s = bus4.out_h;
    ot4_s = bus4.out_tag;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic run_job(input logic [511:0] w, input logic [255:0] h, input logic [31:0] tag, output int lat);
    int n;
    n = 0;
    bus.in_w = w; bus.in_h = h; bus.in_tag = tag; bus.in_valid = 1'b1;
    do begin tick(); n++; end while (!acc && n < 100);
    chk("accept", 256'(acc), 256'(1));
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin tick(); lat++; end
  endtask
  initial begin
    int lat, n, got, nxt_job, last_cyc, l2, l4, l8, sent, rcv;
    logic [255:0] h2, h4, h8;
    logic [255:0] exp_q [$];
    logic [31:0] tag_q [$];
    logic [255:0] bb_exp [4];
    logic [511:0] bb_w [4];
    bus.in_valid = 0; bus.in_w = '0; bus.in_h = '0; bus.in_tag = '0; bus.out_ready = 1;
    bus4.in_valid = 0; bus4.in_w = '0; bus4.in_h = '0; bus4.in_tag = '0; bus4.out_ready = 1;
    repeat (3) tick();
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_out_h", bus.out_h, 256'(0));
    chk("rst_out_tag", 256'(bus.out_tag), 256'(0));
    reset_n = 1;
    tick();
    run_job(EMPT_W, H0, 32'h11, lat);
    chk("empty_lat", 256'(lat), 256'(64));
    chk("empty_h", bus.out_h, EMPT_H);
    chk("empty_tag", 256'(bus.out_tag), 256'(32'h11));
    tick();
    chk("empty_drain", 256'(xfer), 256'(1));
    run_job(ABC_W, H0, 32'h22, lat);
    chk("abc1_lat", 256'(lat), 256'(64));
    chk("abc1_h", bus.out_h, ABC_H);
    chk("abc1_tag", 256'(bus.out_tag), 256'(32'h22));
    tick();
    bus.out_ready = 0;
    run_job(ABC_W, H0, 32'hA, lat);
    chk("bp_lat", 256'(lat), 256'(64));
    bus.in_w = EMPT_W; bus.in_h = H0; bus.in_tag = 32'hB; bus.in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold_h", bus.out_h, ABC_H);
      chk("bp_hold_tag", 256'(bus.out_tag), 256'(32'hA));
      chk("bp_in_ready", 256'(bus.in_ready), 256'(0));
      chk("bp_no_acc", 256'(acc), 256'(0));
    end
    bus.out_ready = 1;
    #1;
    chk("bp_rel_ready", 256'(bus.in_ready), 256'(1));
    tick();
    chk("bp_rel_acc", 256'(acc), 256'(1));
    chk("bp_rel_xfer", 256'(xfer), 256'(1));
    bus.in_valid = 0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin tick(); lat++; end
    chk("bp_next_lat", 256'(lat), 256'(64));
    chk("bp_next_h", bus.out_h, EMPT_H);
    chk("bp_next_tag", 256'(bus.out_tag), 256'(32'hB));
    tick();
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 16; k++) bb_w[j][k*32 +: 32] = $urandom();
      bb_exp[j] = ref_hash(bb_w[j], H0);
    end
    got = 0; nxt_job = 0; n = 0; last_cyc = 0;
    bus.in_w = bb_w[0]; bus.in_h = H0; bus.in_tag = 1; bus.in_valid = 1;
    while (got < 4 && n < 1000) begin
      tick(); n++;
      if (xfer) begin
        chk("b2b_tag", 256'(ot_s), 256'(got + 1));
        chk("b2b_h", oh_s, bb_exp[got]);
        if (got > 0) chk("b2b_period", 256'(cyc - last_cyc), 256'(65));
        last_cyc = cyc;
        got++;
      end
      if (acc) begin
        nxt_job++;
        if (nxt_job < 4) begin
          bus.in_w = bb_w[nxt_job]; bus.in_tag = 32'(nxt_job + 1);
        end else bus.in_valid = 0;
      end
    end
    chk("b2b_count", 256'(got), 256'(4));
    bus.in_w = ABC_W; bus.in_h = H0; bus.in_tag = 32'h55; bus.in_valid = 1;
    n = 0;
    do begin tick(); n++; end while (!acc && n < 100);
    bus.in_valid = 0;
    repeat (40) tick();
    chk("rst_mid_busy_before", 256'(bus.busy), 256'(1));
    reset_n = 0;
    #1;
    chk("rst_mid_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_mid_busy", 256'(bus.busy), 256'(0));
    chk("rst_mid_in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst_mid_out_h", bus.out_h, 256'(0));
    repeat (3) tick();
    reset_n = 1;
    n = 0;
    repeat (70) begin tick(); if (bus.out_valid) n++; end
    chk("rst_mid_no_out", 256'(n), 256'(0));
    run_job(ABC_W, H0, 32'h66, lat);
    chk("rst_after_lat", 256'(lat), 256'(64));
    chk("rst_after_h", bus.out_h, ABC_H);
    chk("rst_after_tag", 256'(bus.out_tag), 256'(32'h66));
    tick();
    bus4.in_w = ABC_W; bus4.in_h = H0; bus4.in_tag = 32'h77; bus4.in_valid = 1;
    tick();
    chk("mr_acc", 256'(acc4), 256'(1));
    bus4.in_valid = 0;
    l2 = 0; l4 = 0; l8 = 0; h2 = '0; h4 = '0; h8 = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus2.out_valid && l2 == 0) begin l2 = i; h2 = bus2.out_h; end
      if (bus4.out_valid && l4 == 0) begin l4 = i; h4 = bus4.out_h; end
      if (bus8.out_valid && l8 == 0) begin l8 = i; h8 = bus8.out_h; end
    end
    chk("abc2_lat", 256'(l2), 256'(32));
    chk("abc4_lat", 256'(l4), 256'(16));
    chk("abc8_lat", 256'(l8), 256'(8));
    chk("abc2_h", h2, ABC_H);
    chk("abc4_h", h4, ABC_H);
    chk("abc8_h", h8, ABC_H);
    sent = 0; rcv = 0; n = 0;
    while (rcv < 1000 && n < 60000) begin
      if (!bus4.in_valid && sent < 1000 && $urandom_range(3) != 0) begin
        for (int k = 0; k < 16; k++) bus4.in_w[k*32 +: 32] = $urandom();
        for (int k = 0; k < 8; k++) bus4.in_h[k*32 +: 32] = $urandom();
        bus4.in_tag = $urandom();
        bus4.in_valid = 1;
      end
      bus4.out_ready = $urandom_range(3) != 0;
      tick(); n++;
      if (xfer4) begin
        if (exp_q.size() == 0) chk("rand_spurious", 256'(1), 256'(0));
        else begin
          chk("rand_h", oh4_s, exp_q.pop_front());
          chk("rand_tag", 256'(ot4_s), 256'(tag_q.pop_front()));
        end
        rcv++;
      end
      if (acc4) begin
        exp_q.push_back(ref_hash(bus4.in_w, bus4.in_h));
        tag_q.push_back(bus4.in_tag);
        sent++;
        bus4.in_valid = 0;
      end
    end
    chk("rand_count", 256'(rcv), 256'(1000));
    chk("rand_left", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
